rv32i_multicycle_control: RTL and testbench
===========================================

# rv32i_multicycle_control

Standalone control unit for the multicycle RV32I datapath. It decodes opcode and funct fields from the instruction register and sequences the datapath muxes and register enables through the FSM below. It covers the full base ISA classes R, I, L, S, B, JAL, JALR, LUI and AUIPC, and supports variable-latency memory through a req/ready handshake with a parametrised timeout.

## Interface
- MEM_TIMEOUT, 16: maximum number of cycles `mem_req` may stay high without `mem_ready`. 0 disables the timeout.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ena  in  1  advance enable. 0 freezes the state and the timeout counter, and forces every enable/req output to 0.
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- alu_zero, alu_lt, alu_ltu  in  1 each  ALU flags for the current cycle (a==b, signed a<b, unsigned a<b)
- mem_ready  in  1  memory accepts/returns data this cycle
- mem_req  out  1  memory access request
- mem_wr_ena  out  1  store strobe, valid only while `mem_req` is high
- mem_src  out  1  memory address select: 0 PC, 1 result
- pc_ena, ir_write, reg_write, alu_ena, mem_data_ena  out  1 each  register enables
- alu_src_a  out  2  0 PC, 1 RF, 2 OLD_PC, 3 ZERO
- alu_src_b  out  2  0 RF, 1 IMM, 2 FOUR
- result_src  out  2  0 ALU, 1 MEM_DATA, 2 ALU_LAST
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- state  out  4  debug view of the FSM state
- illegal_insn  out  1  illegal instruction flag
- timeout_err  out  1  sticky memory-timeout flag

## Operation
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10, JALR 11, UPPER 12, ERROR 15.
- Unlisted outputs default to: enables 0, selects 0, `alu_op` ADD.
- FETCH:
  - Drives `mem_req`=1, `mem_src`=PC, ALU = PC+4.
  - On `mem_ready`: `ir_write`=1, `pc_ena`=1, `result_src`=ALU, go to DECODE. Otherwise hold.
- DECODE:
  - ALU = OLD_PC+IMM with `alu_ena`=1 (branch target).
  - Dispatch: R→EXEC_R; I→EXEC_I; L/S→MEM_ADDR; B→BRANCH; JAL→JAL; JALR→JALR; LUI/AUIPC→UPPER.
  - Illegal: unknown opcode, or B-type with funct3 010/011.
- MEM_ADDR: ALU = RF+IMM, `alu_ena`=1. Load→MEM_READ, store→MEM_WRITE.
- MEM_READ:
  - `mem_req`=1, `mem_src`=result, `result_src`=ALU_LAST.
  - On ready: `mem_data_ena`=1, go to MEM_WB.
- MEM_WB: `result_src`=MEM_DATA, `reg_write`=1, go to FETCH.
- MEM_WRITE:
  - `mem_req`=1, `mem_wr_ena`=1, `mem_src`=result, `result_src`=ALU_LAST.
  - On ready: go to FETCH.
- EXEC_R: `alu_src_a`=RF, `alu_src_b`=RF, `alu_ena`=1, go to ALU_WB.
  - funct3 000: SUB if `funct7_5`, else ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRA if `funct7_5`, else SRL.
  - 110 OR, 111 AND.
- EXEC_I: same as EXEC_R except `alu_src_b`=IMM, and funct3 000 is always ADD. `funct7_5` is consulted only for 101.
- ALU_WB: `result_src`=ALU_LAST, `reg_write`=1, go to FETCH.
- BRANCH:
  - ALU = RF−RF (SUB).
  - taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - If taken: `pc_ena`=1, `result_src`=ALU_LAST. Go to FETCH.
- JALR: ALU = RF+IMM, `alu_ena`=1, go to JAL. Clearing target bit 0 is done in the datapath.
- JAL:
  - `pc_ena`=1, `result_src`=ALU_LAST (target).
  - ALU = OLD_PC+4 with `alu_ena`=1, go to ALU_WB.
- UPPER: `alu_src_a` = ZERO for LUI, OLD_PC for AUIPC; `alu_src_b`=IMM, `alu_ena`=1, go to ALU_WB.
- Timeout:
  - Counter width is $clog2(MEM_TIMEOUT+1). It increments each cycle that `mem_req` is high, `mem_ready` is low and `ena` is high, and clears on ready or on leaving the state.
  - Reaching MEM_TIMEOUT sets `timeout_err`=1 and moves to ERROR.
- ERROR: all enables 0. Held until reset.

## Timing
- Outputs are combinational from state and inputs. State updates on the clk rising edge.
- While `rst` is high, all enables and `mem_req` are 0.
- On the cycle after reset: `state`=FETCH, `illegal_insn`=0, `timeout_err`=0, counter 0.
- Cycles per instruction with zero-wait memory (ready in the same cycle as req): branch 3; R, I, store, JAL, LUI, AUIPC 4; load and JALR 5. Each wait cycle adds 1.
- `ena` low in any state, including during a memory wait, stalls with no side effects. The handshake resumes exactly where it stopped.
- `mem_ready` outside a `mem_req` cycle is ignored.
- `rst` mid-instruction aborts the instruction. No write enable fires on that cycle.

## Configuration
- RV32I_MC_ILLEGAL_TRAP_EN defined: an illegal instruction in DECODE goes to ERROR, and `illegal_insn` stays 1 (sticky) until reset.
- RV32I_MC_ILLEGAL_TRAP_EN undefined: an illegal instruction pulses `illegal_insn` for exactly the DECODE cycle, then returns to FETCH (executes as a NOP). PC is already advanced.
- A timeout goes to ERROR in both builds.

## Test plan
- `add` (op 0110011, funct3 000, funct7_5 0), `mem_ready` tied 1 → states 0,1,6,8,0. `reg_write`=1 only in ALU_WB with `result_src`=2. `alu_op`=ADD in EXEC_R; `sub` gives `alu_op`=1.
- `lw` with `mem_ready` delayed 3 cycles in MEM_READ → `mem_req` held 4 cycles, `mem_data_ena` pulses once, total 8 cycles, then MEM_WB `reg_write`.
- `beq` with `alu_zero`=1 → `pc_ena` in BRANCH with `result_src`=2. With `alu_zero`=0 → no `pc_ena`. `bltu` with `alu_ltu`=1 → taken.
- `jalr` → states 0,1,11,10,8. `pc_ena` in JAL, `reg_write` in ALU_WB. `lui` → `alu_src_a`=3; `auipc` → `alu_src_a`=2.
- MEM_TIMEOUT=4, `mem_ready` held 0 in FETCH → ERROR after 4 cycles, `timeout_err`=1. `ena`=0 for 10 of those cycles delays the error by exactly 10.
- op 0000000: with the macro → ERROR, `illegal_insn` sticky. Without the macro → 1-cycle `illegal_insn` pulse, next state FETCH. `rst` asserted in EXEC_R → FETCH, no `reg_write`.

Source files
------------

// File: rtl/rv32i_multicycle_control.sv
// rv32i_multicycle_control: FSM sequencer for the multicycle RV32I datapath with a req/ready memory timeout.
// Define RV32I_MC_ILLEGAL_TRAP_EN to trap illegal instructions into ERROR with a sticky illegal_insn.
module rv32i_multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_wr_ena,
    output logic       mem_src,
    output logic       pc_ena,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_ena,
    output logic       mem_data_ena,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [3:0] alu_op,
    output logic [3:0] state,
    output logic       illegal_insn,
    output logic       timeout_err
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_UPPER     = 4'd12,
        S_ERROR     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t state_q, state_d, disp;
    logic [CW-1:0] cnt_q, cnt_d;
    logic timeout_q;
    logic act, ill, dec_ill, taken, wait_mem, tmo;
    logic req, wr, pc_e, ir_e, rw_e, alu_e, mde_e;
    logic [3:0] f_op;

    assign act = ena & ~rst;

    always_comb begin
        disp = S_FETCH;
        ill = 1'b0;
        case (op)
            OP_R:     disp = S_EXEC_R;
            OP_I:     disp = S_EXEC_I;
            OP_L:     disp = S_MEM_ADDR;
            OP_S:     disp = S_MEM_ADDR;
            OP_B: begin
                disp = S_BRANCH;
                ill = (funct3[2:1] == 2'b01);
            end
            OP_JAL:   disp = S_JAL;
            OP_JALR:  disp = S_JALR;
            OP_LUI:   disp = S_UPPER;
            OP_AUIPC: disp = S_UPPER;
            default:  ill = 1'b1;
        endcase
    end

    // funct3[0] inverts the base condition; funct3[1] picks unsigned over signed compare
    assign taken = funct3[2] ? ((funct3[1] ? alu_ltu : alu_lt) ^ funct3[0])
                             : (~funct3[1] & (alu_zero ^ funct3[0]));

    always_comb begin
        case (funct3)
            3'b000:  f_op = {3'b000, (state_q == S_EXEC_R) & funct7_5};
            3'b001:  f_op = 4'd2;
            3'b010:  f_op = 4'd3;
            3'b011:  f_op = 4'd4;
            3'b100:  f_op = 4'd5;
            3'b101:  f_op = funct7_5 ? 4'd7 : 4'd6;
            3'b110:  f_op = 4'd8;
            default: f_op = 4'd9;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req = 1'b0;
        wr = 1'b0;
        mem_src = 1'b0;
        pc_e = 1'b0;
        ir_e = 1'b0;
        rw_e = 1'b0;
        alu_e = 1'b0;
        mde_e = 1'b0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        result_src = 2'd0;
        alu_op = 4'd0;
        case (state_q)
            S_FETCH: begin
                req = 1'b1;
                alu_src_b = 2'd2;
                ir_e = mem_ready;
                pc_e = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                alu_e = 1'b1;
`ifdef RV32I_MC_ILLEGAL_TRAP_EN
                state_d = ill ? S_ERROR : disp;
`else
                state_d = ill ? S_FETCH : disp;
`endif
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_e = 1'b1;
                state_d = (op == OP_S) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                req = 1'b1;
                mem_src = 1'b1;
                result_src = 2'd2;
                mde_e = mem_ready;
                state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                result_src = 2'd1;
                rw_e = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WRITE: begin
                req = 1'b1;
                wr = 1'b1;
                mem_src = 1'b1;
                result_src = 2'd2;
                state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = (state_q == S_EXEC_I) ? 2'd1 : 2'd0;
                alu_e = 1'b1;
                alu_op = f_op;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                result_src = 2'd2;
                rw_e = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'd1;
                alu_op = 4'd1;
                pc_e = taken;
                result_src = taken ? 2'd2 : 2'd0;
                state_d = S_FETCH;
            end
            S_JAL: begin
                pc_e = 1'b1;
                result_src = 2'd2;
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                alu_e = 1'b1;
                state_d = S_ALU_WB;
            end
            S_JALR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_e = 1'b1;
                state_d = S_JAL;
            end
            S_UPPER: begin
                alu_src_a = (op == OP_LUI) ? 2'd3 : 2'd2;
                alu_src_b = 2'd1;
                alu_e = 1'b1;
                state_d = S_ALU_WB;
            end
            default: state_d = S_ERROR;
        endcase
    end

    // the counter only sees raw req, so a stalled cycle neither counts nor clears
    assign wait_mem = req & ~mem_ready;
    assign tmo = (MEM_TIMEOUT != 0) && wait_mem && (cnt_q == CW'(MEM_TIMEOUT - 1));
    assign cnt_d = wait_mem ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q <= '0;
            timeout_q <= 1'b0;
        end else if (ena) begin
            state_q <= tmo ? S_ERROR : state_d;
            cnt_q <= cnt_d;
            timeout_q <= timeout_q | tmo;
        end
    end

    assign dec_ill = act & (state_q == S_DECODE) & ill;

`ifdef RV32I_MC_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst) illegal_q <= 1'b0;
        else illegal_q <= illegal_q | dec_ill;
    end

    assign illegal_insn = illegal_q | dec_ill;
`else
    assign illegal_insn = dec_ill;
`endif

    assign mem_req = req & act;
    assign mem_wr_ena = wr & act;
    assign pc_ena = pc_e & act;
    assign ir_write = ir_e & act;
    assign reg_write = rw_e & act;
    assign alu_ena = alu_e & act;
    assign mem_data_ena = mde_e & act;
    assign state = state_q;
    assign timeout_err = timeout_q;
endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// tb_rv32i_multicycle_control: vector table, corner sequences and random instructions
// checked against a per-instruction cost model of the control unit.
module tb_rv32i_multicycle_control;
    logic clk = 1'b0;
    logic rst, ena, funct7_5, alu_zero, alu_lt, alu_ltu, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic mem_req, mem_wr_ena, mem_src, pc_ena, ir_write, reg_write, alu_ena, mem_data_ena;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_op, state;
    logic illegal_insn, timeout_err;

    always #5 clk = ~clk;

    rv32i_multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_wr_ena(mem_wr_ena), .mem_src(mem_src), .pc_ena(pc_ena),
        .ir_write(ir_write), .reg_write(reg_write), .alu_ena(alu_ena),
        .mem_data_ena(mem_data_ena), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_op(alu_op), .state(state),
        .illegal_insn(illegal_insn), .timeout_err(timeout_err)
    );

`ifdef RV32I_MC_ILLEGAL_TRAP_EN
    localparam int NCLS = 8;
`else
    localparam int NCLS = 9;
`endif

    typedef struct {
        string name;
        logic [6:0] o;
        logic [2:0] f3;
        logic f7, z, lt, ltu;
        int n;
        logic [19:0] path;
        logic [3:0] aop;
        logic [1:0] sa;
        logic pc2;
    } vec_t;

    int total = 0;
    int bad = 0;
    int n_cyc, n_stall, n_rw, n_pc, n_ir, n_req, n_mde, n_wr, n_ill;
    logic [3:0] aop_seen;
    bit saw_exec, done;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [3:0] exp_alu(input bit is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0: return (is_r && f7) ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return f7 ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    // cost of one instruction: cycles, memory accesses and enable pulses with zero-wait memory
    function automatic void model(input logic [6:0] o, input logic [2:0] f3, input logic z, lt, ltu,
                                  output int cpi, acc, rw, pc, ld, st, il);
        bit tk;
        ld = 0; st = 0; il = 0; acc = 1; pc = 1; rw = 1;
        case (f3)
            3'd0: tk = z;
            3'd1: tk = !z;
            3'd4: tk = lt;
            3'd5: tk = !lt;
            3'd6: tk = ltu;
            default: tk = !ltu;
        endcase
        case (o)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: cpi = 4;
            7'b0000011: begin cpi = 5; acc = 2; ld = 1; end
            7'b0100011: begin cpi = 4; acc = 2; rw = 0; st = 1; end
            7'b1101111: begin cpi = 4; pc = 2; end
            7'b1100111: begin cpi = 5; pc = 2; end
            7'b1100011: begin
                rw = 0;
                if (f3 == 3'd2 || f3 == 3'd3) begin cpi = 2; il = 1; end
                else begin cpi = 3; pc = 1 + int'(tk); end
            end
            default: begin cpi = 2; rw = 0; il = 1; end
        endcase
    endfunction

    // runs one instruction from FETCH back to FETCH, w0/w1 wait cycles on the two accesses
    task automatic run_insn(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int w0, input int w1, input int stall_pct);
        int left;
        bit seen;
        op = o; funct3 = f3; funct7_5 = f7;
        n_cyc = 0; n_stall = 0; n_rw = 0; n_pc = 0; n_ir = 0; n_req = 0; n_mde = 0; n_wr = 0; n_ill = 0;
        saw_exec = 0; done = 0; seen = 0; left = w0; aop_seen = 4'd0;
        for (int k = 0; k < 120; k++) begin
            ena = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
            mem_ready = (left == 0);
            #1;
            if (seen && state == 4'd0) begin
                done = 1;
                break;
            end
            if (state == 4'd1) seen = 1;
            n_cyc++;
            n_stall += int'(!ena);
            n_rw += int'(reg_write);
            n_pc += int'(pc_ena);
            n_ir += int'(ir_write);
            n_req += int'(mem_req);
            n_mde += int'(mem_data_ena);
            n_wr += int'(mem_wr_ena & mem_req);
            n_ill += int'(illegal_insn);
            if (state == 4'd6 || state == 4'd7) begin
                saw_exec = 1;
                aop_seen = alu_op;
            end
            if (mem_req) begin
                if (mem_ready) left = w1;
                else left--;
            end
            cyc();
        end
        chk("insn_done", 32'(done), 1);
    endtask

    task automatic measure_timeout(input int stall_at, input int stall_len, output int cycles);
        cycles = 0;
        for (int k = 0; k < 60; k++) begin
            ena = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 : 1'b1;
            mem_ready = 1'b0;
            #1;
            if (state == 4'd15) break;
            cycles++;
            cyc();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t vt[$];
        logic [3:0] es;
        logic [6:0] o;
        logic [2:0] f3;
        logic f7;
        logic [31:0] a, b;
        int cls, v, w0, w1, tcyc, cpi, acc, rw, pc, ld, st, il, waits;
        vt.push_back('{"add",   7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 20'h01680, 4'd0, 2'd1, 1'b0});
        vt.push_back('{"sub",   7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 20'h01680, 4'd1, 2'd1, 1'b0});
        vt.push_back('{"sra",   7'b0110011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4, 20'h01680, 4'd7, 2'd1, 1'b0});
        vt.push_back('{"and",   7'b0110011, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4, 20'h01680, 4'd9, 2'd1, 1'b0});
        vt.push_back('{"addi",  7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 20'h01780, 4'd0, 2'd1, 1'b0});
        vt.push_back('{"srli",  7'b0010011, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4, 20'h01780, 4'd6, 2'd1, 1'b0});
        vt.push_back('{"srai",  7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4, 20'h01780, 4'd7, 2'd1, 1'b0});
        vt.push_back('{"beq_t", 7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 20'h01900, 4'd1, 2'd1, 1'b1});
        vt.push_back('{"beq_n", 7'b1100011, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 20'h01900, 4'd1, 2'd1, 1'b0});
        vt.push_back('{"bltu",  7'b1100011, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 3, 20'h01900, 4'd1, 2'd1, 1'b1});
        vt.push_back('{"bge",   7'b1100011, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 3, 20'h01900, 4'd1, 2'd1, 1'b0});
        vt.push_back('{"jalr",  7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 20'h01ba8, 4'd0, 2'd1, 1'b0});
        vt.push_back('{"jal",   7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 20'h01a80, 4'd0, 2'd2, 1'b1});
        vt.push_back('{"lui",   7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 20'h01c80, 4'd0, 2'd3, 1'b0});
        vt.push_back('{"auipc", 7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 20'h01c80, 4'd0, 2'd2, 1'b0});
        vt.push_back('{"sw",    7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4, 20'h01250, 4'd0, 2'd1, 1'b0});
        vt.push_back('{"lw",    7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5, 20'h01234, 4'd0, 2'd1, 1'b0});

        rst = 1'b1; ena = 1'b1; op = 7'b0110011; funct3 = 3'd0; funct7_5 = 1'b0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = 1'b1;
        cyc();
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_pc_ena", 32'(pc_ena), 0);
        chk("rst_ir_write", 32'(ir_write), 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_state", 32'(state), 0);
        chk("post_rst_illegal", 32'(illegal_insn), 0);
        chk("post_rst_timeout", 32'(timeout_err), 0);
        chk("post_rst_mem_req", 32'(mem_req), 1);

        foreach (vt[i]) begin
            op = vt[i].o; funct3 = vt[i].f3; funct7_5 = vt[i].f7;
            alu_zero = vt[i].z; alu_lt = vt[i].lt; alu_ltu = vt[i].ltu;
            ena = 1'b1; mem_ready = 1'b1;
            for (int k = 0; k < vt[i].n; k++) begin
                #1;
                es = vt[i].path[19 - 4 * k -: 4];
                chk({vt[i].name, "_state"}, 32'(state), 32'(es));
                chk({vt[i].name, "_reg_write"}, 32'(reg_write), 32'(es == 4'd4 || es == 4'd8));
                if (es == 4'd4 || es == 4'd8)
                    chk({vt[i].name, "_result_src"}, 32'(result_src), (es == 4'd4) ? 1 : 2);
                if (k == 2) begin
                    chk({vt[i].name, "_alu_op"}, 32'(alu_op), 32'(vt[i].aop));
                    chk({vt[i].name, "_src_a"}, 32'(alu_src_a), 32'(vt[i].sa));
                    chk({vt[i].name, "_pc_ena"}, 32'(pc_ena), 32'(vt[i].pc2));
                end
                cyc();
            end
            #1;
            chk({vt[i].name, "_end_state"}, 32'(state), 0);
        end

        run_insn(7'b0000011, 3'd2, 1'b0, 0, 3, 0);
        chk("lw_wait_cycles", n_cyc, 8);
        chk("lw_wait_req", n_req, 5);
        chk("lw_wait_mde", n_mde, 1);
        chk("lw_wait_rw", n_rw, 1);

        op = 7'b0110011; funct3 = 3'd0; funct7_5 = 1'b0; ena = 1'b1; mem_ready = 1'b1;
        cyc();
        cyc();
        #1;
        chk("rstmid_exec_state", 32'(state), 6);
        rst = 1'b1;
        #1;
        chk("rstmid_reg_write", 32'(reg_write), 0);
        chk("rstmid_alu_ena", 32'(alu_ena), 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rstmid_after_state", 32'(state), 0);
        chk("rstmid_after_rw", 32'(reg_write), 0);

        op = 7'b0000000;
        #1;
        chk("ill_fetch_flag", 32'(illegal_insn), 0);
        cyc();
        #1;
        chk("ill_decode_state", 32'(state), 1);
        chk("ill_decode_flag", 32'(illegal_insn), 1);
        cyc();
        #1;
`ifdef RV32I_MC_ILLEGAL_TRAP_EN
        chk("ill_next_state", 32'(state), 15);
        chk("ill_next_flag", 32'(illegal_insn), 1);
        cyc();
        #1;
        chk("ill_sticky_flag", 32'(illegal_insn), 1);
        chk("ill_sticky_state", 32'(state), 15);
`else
        chk("ill_next_state", 32'(state), 0);
        chk("ill_next_flag", 32'(illegal_insn), 0);
`endif
        do_reset();

        measure_timeout(0, 0, tcyc);
        chk("tmo_cycles", tcyc, 4);
        chk("tmo_err", 32'(timeout_err), 1);
        chk("tmo_err_mem_req", 32'(mem_req), 0);
        do_reset();
        chk("tmo_rst_clear", 32'(timeout_err), 0);
        measure_timeout(2, 10, tcyc);
        chk("tmo_stall_cycles", tcyc, 14);
        chk("tmo_stall_err", 32'(timeout_err), 1);
        do_reset();

        for (int i = 0; i < 80; i++) begin
            cls = int'($urandom_range(NCLS));
            f3 = 3'($urandom_range(7));
            f7 = 1'($urandom_range(1));
            case (cls)
                0: o = 7'b0110011;
                1: o = 7'b0010011;
                2: o = 7'b0000011;
                3: o = 7'b0100011;
                4: begin
                    o = 7'b1100011;
                    v = int'($urandom_range(5));
                    f3 = 3'((v < 2) ? v : v + 2);
                end
                5: o = 7'b1101111;
                6: o = 7'b1100111;
                7: o = 7'b0110111;
                8: o = 7'b0010111;
                default: begin
                    if ($urandom_range(1) == 1) o = 7'b0000000;
                    else begin
                        o = 7'b1100011;
                        f3 = {2'b01, 1'($urandom_range(1))};
                    end
                end
            endcase
            a = $urandom;
            b = ($urandom_range(3) == 0) ? a : $urandom;
            alu_zero = (a == b);
            alu_lt = ($signed(a) < $signed(b));
            alu_ltu = (a < b);
            w0 = int'($urandom_range(3));
            w1 = int'($urandom_range(3));
            run_insn(o, f3, f7, w0, w1, 25);
            model(o, f3, alu_zero, alu_lt, alu_ltu, cpi, acc, rw, pc, ld, st, il);
            waits = w0 + ((acc == 2) ? w1 : 0);
            chk("rnd_cycles", n_cyc, cpi + waits + n_stall);
            chk("rnd_mem_req", n_req, acc + waits);
            chk("rnd_reg_write", n_rw, rw);
            chk("rnd_pc_ena", n_pc, pc);
            chk("rnd_ir_write", n_ir, 1);
            chk("rnd_mem_data", n_mde, ld);
            chk("rnd_mem_wr", n_wr, st ? 1 + w1 : 0);
            chk("rnd_illegal", n_ill, il);
            if (o == 7'b0110011 || o == 7'b0010011) begin
                chk("rnd_exec_seen", 32'(saw_exec), 1);
                chk("rnd_alu_op", 32'(aop_seen), 32'(exp_alu(o == 7'b0110011, f3, f7)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
